// File: rtl/mp_addsub_sequencer.sv
// rtl/mp_addsub_sequencer.sv - multi-precision add/sub sequencer, one word per cycle, LS word first
// Optional rsp_zero output enabled by MP_ADDSUB_ZERO_FLAG_EN.
module mp_addsub_sequencer #(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_sub,
  input  logic                            req_signed,
  input  logic                            req_carry_in,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] req_a,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] req_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] rsp_result,
  output logic                            rsp_carry_out,
`ifdef MP_ADDSUB_ZERO_FLAG_EN
  output logic                            rsp_zero,
`endif
  output logic                            rsp_overflow
);

  localparam int W     = NUM_WORDS * WORD_WIDTH;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic                 sub_q;
  logic                 signed_q;
  logic                 carry_q;
  logic [IDX_W-1:0]     idx_q;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
  logic                 zero_q;
`endif

  logic [WORD_WIDTH-1:0] a_w;
  logic [WORD_WIDTH-1:0] b_w;
  logic [WORD_WIDTH-1:0] r_w;
  logic [WORD_WIDTH:0]   full_w;
  logic [WORD_WIDTH-1:0] low_w;
  logic                  c_out;
  logic                  c_into_msb;

  // The low-bits sum exposes the carry/borrow into the word MSB for signed overflow.
  always_comb begin
    a_w = a_q[idx_q*WORD_WIDTH +: WORD_WIDTH];
    b_w = b_q[idx_q*WORD_WIDTH +: WORD_WIDTH];
    if (sub_q) begin
      full_w = {1'b0, a_w} - {1'b0, b_w} - (WORD_WIDTH+1)'(carry_q);
      low_w  = {1'b0, a_w[WORD_WIDTH-2:0]} - {1'b0, b_w[WORD_WIDTH-2:0]} - WORD_WIDTH'(carry_q);
    end else begin
      full_w = {1'b0, a_w} + {1'b0, b_w} + (WORD_WIDTH+1)'(carry_q);
      low_w  = {1'b0, a_w[WORD_WIDTH-2:0]} + {1'b0, b_w[WORD_WIDTH-2:0]} + WORD_WIDTH'(carry_q);
    end
    r_w        = full_w[WORD_WIDTH-1:0];
    c_out      = full_w[WORD_WIDTH];
    c_into_msb = low_w[WORD_WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_carry_out <= 1'b0;
      rsp_overflow  <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      sub_q         <= 1'b0;
      signed_q      <= 1'b0;
      carry_q       <= 1'b0;
      idx_q         <= '0;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
      zero_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q       <= req_a;
            b_q       <= req_b;
            sub_q     <= req_sub;
            signed_q  <= req_signed;
            carry_q   <= req_carry_in;
            idx_q     <= '0;
            req_ready <= 1'b0;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
            zero_q    <= 1'b1;
`endif
            state     <= RUN;
          end
        end
        RUN: begin
          rsp_result[idx_q*WORD_WIDTH +: WORD_WIDTH] <= r_w;
          carry_q <= c_out;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
          zero_q  <= zero_q & (r_w == '0);
`endif
          if (idx_q == LAST_IDX) begin
            rsp_carry_out <= c_out;
            rsp_overflow  <= signed_q ? (c_into_msb ^ c_out) : c_out;
            rsp_valid     <= 1'b1;
            state         <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MP_ADDSUB_ZERO_FLAG_EN
  assign rsp_zero = zero_q;
`endif

endmodule

// File: tb/tb_mp_addsub_sequencer.sv
// tb/tb_mp_addsub_sequencer.sv - directed self-checking bench for mp_addsub_sequencer (8-bit words, 4 words)
module tb_mp_addsub_sequencer;

  localparam int WW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_sub, req_signed, req_carry_in;
  logic [31:0]   req_a, req_b;
  logic          rsp_valid, rsp_ready, rsp_carry_out, rsp_overflow;
  logic [31:0]   rsp_result;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
  logic          rsp_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mp_addsub_sequencer #(.WORD_WIDTH(WW), .NUM_WORDS(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sub      (req_sub),
    .req_signed   (req_signed),
    .req_carry_in (req_carry_in),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry_out(rsp_carry_out),
`ifdef MP_ADDSUB_ZERO_FLAG_EN
    .rsp_zero     (rsp_zero),
`endif
    .rsp_overflow (rsp_overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a request at a negedge; returns one negedge after the accepting posedge.
  task automatic send(input logic sub, input logic sgn, input logic cin, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_sub = sub; req_signed = sgn; req_carry_in = cin; req_a = a; req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(NW));
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] er, input logic ec, input logic eo);
    check_eq({tag, "_result"}, 64'(rsp_result), 64'(er));
    check_eq({tag, "_carry"}, 64'(rsp_carry_out), 64'(ec));
    check_eq({tag, "_ovf"}, 64'(rsp_overflow), 64'(eo));
`ifdef MP_ADDSUB_ZERO_FLAG_EN
    check_eq({tag, "_zero"}, 64'(rsp_zero), 64'(er == 32'h0));
`endif
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, "_rel_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rel_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic sub, input logic sgn, input logic cin,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic eo);
    send(sub, sgn, cin, a, b);
    wait_rsp(tag);
    check_rsp(tag, er, ec, eo);
    release_rsp(tag);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_sub = 1'b0; req_signed = 1'b0; req_carry_in = 1'b0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_result", 64'(rsp_result), 64'd0);
    check_eq("rst_flags", {62'd0, rsp_carry_out, rsp_overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // tag, sub, signed, cin, a, b, result, carry/borrow, overflow
    run_op("t1_add_ripple",  1'b0, 1'b0, 1'b0, 32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0);
    run_op("t2_add_cin",     1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b1);
    run_op("t3_sub_borrow",  1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1);
    run_op("t3_sub_sovf",    1'b1, 1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("t4_add_sovf",    1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    run_op("t_add_neg",      1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0);
    run_op("t_sub_bin",      1'b1, 1'b0, 1'b1, 32'h00000010, 32'h00000005, 32'h0000000A, 1'b0, 1'b0);
    run_op("t_add_mixed",    1'b0, 1'b0, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0);

    // Backpressure: second request offered while the response is held.
    send(1'b0, 1'b0, 1'b0, 32'h000000FF, 32'h00000001);
    wait_rsp("t5_first");
    req_sub = 1'b0; req_signed = 1'b0; req_carry_in = 1'b0;
    req_a = 32'h00000001; req_b = 32'h00000001; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t5_hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("t5_hold_result", 64'(rsp_result), 64'h100);
      check_eq("t5_hold_flags", {62'd0, rsp_carry_out, rsp_overflow}, 64'd0);
      check_eq("t5_hold_req_ready", 64'(req_ready), 64'd0);
    end
    release_rsp("t5");
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("t5_second_accepted", 64'(req_ready), 64'd0);
    wait_rsp("t5_second");
    check_rsp("t5_second", 32'h00000002, 1'b0, 1'b0);
    release_rsp("t5_second");

    // Asynchronous reset two cycles into RUN.
    send(1'b0, 1'b0, 1'b0, 32'h01020304, 32'h10203040);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t6_req_ready", 64'(req_ready), 64'd1);
    check_eq("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("t6_result", 64'(rsp_result), 64'd0);
    check_eq("t6_flags", {62'd0, rsp_carry_out, rsp_overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("t6_no_rsp", 64'(rsp_valid), 64'd0);
    end
    run_op("t6_after", 1'b0, 1'b0, 1'b0, 32'h01020304, 32'h10203040, 32'h11223344, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_addsub_sequencer.md
Name: mp_addsub_sequencer

Overview:
- Multi-precision add/subtract controller.
- Takes a wide operand pair (NUM_WORDS words of WORD_WIDTH bits) and sequences one WORD_WIDTH add/sub per cycle, least-significant word first, chaining carry/borrow between words.
- Sits between the integer issue logic and the word-width integer adder/subtractor datapath, so wide arithmetic reuses one narrow adder.
- Valid/ready handshake on the request and response sides.

Parameters:
- WORD_WIDTH, 16, width of one datapath word (must be >= 2).
- NUM_WORDS, 4, words per operand (must be >= 1); operand width is W = NUM_WORDS*WORD_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_sub  input  1  0 = a+b+cin; 1 = a-b-bin.
- req_signed  input  1  selects signed overflow reporting.
- req_carry_in  input  1  carry-in (add) or borrow-in (sub) for word 0.
- req_a  input  W  operand A.
- req_b  input  W  operand B.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_result  output  W  result.
- rsp_carry_out  output  1  add: carry out of the MSB; sub: borrow out (1 iff unsigned a < b+bin).
- rsp_overflow  output  1  req_signed=1: two's-complement overflow of the W-bit result; req_signed=0: equals rsp_carry_out.

Behaviour:
- Reset values (async, immediate): state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_carry_out=0, rsp_overflow=0, word index=0, internal carry=0.
- States: IDLE, RUN, DONE.
- req_ready=1 only in IDLE. rsp_valid=1 only in DONE.
- IDLE:
  - Accept on req_valid & req_ready.
  - Latch a, b, sub, signed flags; carry register = req_carry_in; index=0; go to RUN.
- RUN, each cycle, on word i:
  - add: {c, r_i} = a_i + b_i + c.
  - sub: {bw, r_i} = a_i - b_i - bw (bw = 1 on wraparound).
  - Write r_i into result slice i, update the carry register, index++.
  - On the edge processing word NUM_WORDS-1: latch rsp_carry_out; compute overflow from the MSB word (carry into MSB XOR carry out of MSB, same rule for sub with borrow); go to DONE.
- Latency: rsp_valid rises exactly NUM_WORDS cycles after the accepting edge. NUM_WORDS=1 gives 1 cycle.
- DONE:
  - Outputs stable while rsp_valid & !rsp_ready (no change for any duration of backpressure).
  - On rsp_ready: go to IDLE and drop rsp_valid.
  - rsp_result keeps its last value in IDLE.
- No overlap: a new request is accepted only in IDLE, at the earliest the cycle after the response handshake. req_* inputs are ignored outside IDLE.
- rsp_result must not be driven with partial values visible as valid; partial words may update the register during RUN, but rsp_valid stays 0.
- Reset mid-RUN or mid-DONE: abort immediately, return to reset values. The in-flight request is lost with no response.
- Index counter width is clog2(NUM_WORDS) with a minimum of 1; it never wraps past NUM_WORDS-1.

Optional Feature:
- Macro: MP_ADDSUB_ZERO_FLAG_EN.
- Defined: adds output rsp_zero (1 bit).
  - Reset 0.
  - Computed incrementally: cleared to 1 at accept, ANDed with (r_i==0) each RUN cycle.
  - Valid with rsp_valid; 1 iff rsp_result == 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (WORD_WIDTH=8, NUM_WORDS=4):
1. add, a=0x00FFFFFF, b=0x00000001, cin=0 -> rsp_valid 4 cycles after accept; result=0x01000000, carry_out=0, overflow=0.
2. add unsigned, a=0xFFFFFFFF, b=0x00000000, cin=1 -> result=0x00000000, carry_out=1, overflow=1, rsp_zero=1 (if enabled).
3. sub unsigned, a=0x00000000, b=0x00000001, bin=0 -> result=0xFFFFFFFF, carry_out(borrow)=1; sub signed, a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, overflow=1.
4. add signed, a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, carry_out=0.
5. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> result/flags stable, req_ready=0, second req_valid not accepted; accepted the cycle after the rsp handshake.
6. Assert rst 2 cycles into RUN -> req_ready=1, rsp_valid=0, outputs 0 asynchronously; next request completes normally with correct result.
